// File: rtl/red_pitaya_decimate_block_pkg.sv
// ============================================================================
// Module : red_pitaya_decimate_block_pkg
// Brief  : Shared pyrpl decimator constants, FSM encoding and L clamp helper.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package red_pitaya_decimate_block_pkg;

    localparam int unsigned MAXLOG2_DEFAULT = 10;

    typedef logic [0:0] decim_state_t;
    localparam decim_state_t ST_FILL = 1'b0;
    localparam decim_state_t ST_RUN  = 1'b1;

    function automatic logic [3:0] clamp_log2(input logic [3:0] req, input int unsigned max_log2);
        logic [31:0] max_v;
        max_v = max_log2;
        return (32'(req) > max_v) ? max_v[3:0] : req;
    endfunction

endpackage

`default_nettype wire

// File: rtl/red_pitaya_decimate_block_ctrl.sv
// ============================================================================
// Module : red_pitaya_decim_ctrl
// Brief  : Window counter, L-change/clear restart detection and FILL/RUN FSM.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module red_pitaya_decim_ctrl
    import red_pitaya_decimate_block_pkg::*;
#(
    parameter int unsigned MAXLOG2 = MAXLOG2_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] l_eff,
    input  logic       clear,
    output logic       window_end,
    output logic       restart,
    output logic       settled
);

    localparam logic [MAXLOG2-1:0] ONE = MAXLOG2'(1);

    logic [3:0]         l_r;
    logic               fresh;
    logic [MAXLOG2-1:0] count;
    logic [MAXLOG2-1:0] last_count;
    decim_state_t       state;
    decim_state_t       state_next;

    // The first edge after reset loads L_r without counting as a change, so
    // that edge already holds sample 0 of the first window.
    assign restart    = clear | (~fresh & (l_eff != l_r));
    assign last_count = (ONE << l_eff) - ONE;
    assign window_end = ~restart & (count == last_count);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            l_r   <= 4'd0;
            fresh <= 1'b1;
            count <= '0;
        end else begin
            l_r   <= l_eff;
            fresh <= 1'b0;
            if (restart || window_end) begin
                count <= '0;
            end else begin
                count <= count + ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_FILL;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (restart) begin
            state_next = ST_FILL;
        end else if (window_end) begin
            state_next = ST_RUN;
        end
    end

    always_comb begin
        settled = (state == ST_RUN);
    end

endmodule

`default_nettype wire

// File: rtl/red_pitaya_decimate_block.sv
// ============================================================================
// Module : red_pitaya_decimate_block
// Brief  : Boxcar decimator by 2^L; define PYRPL_DECIM_ROUND_EN for rounding.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module red_pitaya_decimate_block
    import red_pitaya_decimate_block_pkg::*;
#(
    parameter int unsigned SIGNALBITS = 14,
    parameter int unsigned MAXLOG2    = MAXLOG2_DEFAULT
) (
    input  logic                         clk_i,
    input  logic                         rstn_i,
    input  logic [3:0]                   log2_decim,
    input  logic                         clear_i,
    input  logic signed [SIGNALBITS-1:0] dat_i,
    output logic signed [SIGNALBITS-1:0] dat_o,
    output logic                         valid_o,
    output logic                         settled_o
);

    localparam int unsigned ACCW = SIGNALBITS + MAXLOG2;
    localparam logic signed [ACCW-1:0] ACC_ONE = ACCW'(1);

    logic [3:0]                   l_eff;
    logic                         window_end;
    logic                         restart;
    logic signed [ACCW-1:0]       acc;
    logic signed [ACCW-1:0]       sum;
    logic signed [ACCW-1:0]       round_add;
    logic signed [SIGNALBITS-1:0] dec_sample;

    assign l_eff = clamp_log2(log2_decim, MAXLOG2);

    red_pitaya_decim_ctrl #(
        .MAXLOG2 (MAXLOG2)
    ) u_ctrl (
        .clk        (clk_i),
        .rst_n      (rstn_i),
        .l_eff      (l_eff),
        .clear      (clear_i),
        .window_end (window_end),
        .restart    (restart),
        .settled    (settled_o)
    );

    assign sum = acc + ACCW'(dat_i);

`ifdef PYRPL_DECIM_ROUND_EN
    assign round_add = (l_eff == 4'd0) ? '0 : (ACC_ONE <<< (l_eff - 4'd1));
`else
    assign round_add = '0;
`endif

    // The average of 2^L W-bit samples always fits back into W bits.
    assign dec_sample = SIGNALBITS'((sum + round_add) >>> l_eff);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            acc     <= '0;
            dat_o   <= '0;
            valid_o <= 1'b0;
        end else if (restart) begin
            acc     <= '0;
            valid_o <= 1'b0;
        end else if (window_end) begin
            acc     <= '0;
            dat_o   <= dec_sample;
            valid_o <= 1'b1;
        end else begin
            acc     <= sum;
            valid_o <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_red_pitaya_decimate_block.sv
// ============================================================================
// Module : tb_red_pitaya_decimate_block
// Brief  : Directed self-checking bench for the boxcar decimator.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_red_pitaya_decimate_block;

`ifdef PYRPL_DECIM_ROUND_EN
    localparam int EXP_POS = 2;
    localparam int EXP_NEG = -5;
`else
    localparam int EXP_POS = 1;
    localparam int EXP_NEG = -6;
`endif

    logic               clk = 1'b0;
    logic               rstn = 1'b0;
    logic [3:0]         log2 = 4'd2;
    logic               clear = 1'b0;
    logic signed [13:0] dat = '0;
    logic signed [13:0] dat_o;
    logic               valid;
    logic               settled;

    int n_checks = 0;
    int n_fail   = 0;

    red_pitaya_decimate_block #(
        .SIGNALBITS (14),
        .MAXLOG2    (10)
    ) dut (
        .clk_i      (clk),
        .rstn_i     (rstn),
        .log2_decim (log2),
        .clear_i    (clear),
        .dat_i      (dat),
        .dat_o      (dat_o),
        .valid_o    (valid),
        .settled_o  (settled)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int d, input logic clr);
        dat   = 14'(d);
        clear = clr;
        @(posedge clk);
        #1;
    endtask

    // Feeds n samples of d; strobe expected only on the last with value exp_d.
    task automatic run_window(input string tag, input int n, input int d, input int exp_d);
        for (int i = 1; i <= n; i++) begin
            cyc(d, 1'b0);
            check({tag, "_valid"}, 32'(valid), (i == n) ? 32'sd1 : 32'sd0);
        end
        check({tag, "_dat"}, dat_o, exp_d);
        check({tag, "_settled"}, 32'(settled), 1);
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_dat", dat_o, 0);
        check("rst_valid", 32'(valid), 0);
        check("rst_settled", 32'(settled), 0);
        rstn = 1'b1;

        // L=2, constant 100: strobe every 4th cycle, settled with first strobe
        for (int k = 0; k < 12; k++) begin
            cyc(100, 1'b0);
            check("c100_valid", 32'(valid), (k % 4 == 3) ? 32'sd1 : 32'sd0);
            check("c100_settled", 32'(settled), (k >= 3) ? 32'sd1 : 32'sd0);
            if (k % 4 == 3) check("c100_dat", dat_o, 100);
        end

        // Truncation / rounding boundaries
        cyc(1, 1'b0); cyc(2, 1'b0); cyc(2, 1'b0); cyc(2, 1'b0);
        check("pos_valid", 32'(valid), 1);
        check("pos_dat", dat_o, EXP_POS);
        cyc(-5, 1'b0); cyc(-5, 1'b0); cyc(-5, 1'b0); cyc(-6, 1'b0);
        check("neg_valid", 32'(valid), 1);
        check("neg_dat", dat_o, EXP_NEG);
        cyc(0, 1'b0);
        check("hold_valid", 32'(valid), 0);
        check("hold_dat", dat_o, EXP_NEG);

        // L=3, clear at sample 5
        log2 = 4'd3;
        cyc(0, 1'b0);
        check("l3chg_valid", 32'(valid), 0);
        check("l3chg_settled", 32'(settled), 0);
        for (int i = 0; i < 5; i++) cyc(50, 1'b0);
        cyc(50, 1'b1);
        check("clr5_valid", 32'(valid), 0);
        check("clr5_settled", 32'(settled), 0);
        for (int i = 1; i <= 8; i++) begin
            cyc(10 * i, 1'b0);
            check("postclr_valid", 32'(valid), (i == 8) ? 32'sd1 : 32'sd0);
        end
        check("postclr_dat", dat_o, 45);
        check("postclr_settled", 32'(settled), 1);

        // Clear on the window-end cycle wins
        for (int i = 0; i < 7; i++) cyc(0, 1'b0);
        cyc(0, 1'b1);
        check("clrend_valid", 32'(valid), 0);
        check("clrend_settled", 32'(settled), 0);
        check("clrend_dat", dat_o, 45);
        run_window("after_clrend", 8, -3, -3);

        // L changed 2->3 mid-window
        log2 = 4'd2;
        cyc(1000, 1'b0);
        cyc(1000, 1'b0);
        cyc(1000, 1'b0);
        check("l2mid_valid", 32'(valid), 0);
        log2 = 4'd3;
        cyc(1000, 1'b0);
        check("l23chg_valid", 32'(valid), 0);
        check("l23chg_settled", 32'(settled), 0);
        check("l23chg_dat", dat_o, -3);
        run_window("after_l23", 8, 7, 7);

        // Largest window, log2_decim=15 clamps to 10; 15->10 is not a change
        log2 = 4'd15;
        cyc(0, 1'b0);
        check("l15chg_valid", 32'(valid), 0);
        run_window("l15_max", 1024, 8191, 8191);
        run_window("l15_min", 1024, -8192, -8192);
        log2 = 4'd10;
        run_window("l10_max", 1024, 8191, 8191);

        // Asynchronous reset at sample 3 of an L=2 window
        log2 = 4'd2;
        cyc(0, 1'b0);
        run_window("prereset", 4, 12, 12);
        for (int i = 0; i < 3; i++) cyc(500, 1'b0);
        #2;
        rstn = 1'b0;
        #1;
        check("async_dat", dat_o, 0);
        check("async_valid", 32'(valid), 0);
        check("async_settled", 32'(settled), 0);
        cyc(500, 1'b0);
        cyc(500, 1'b0);
        check("inrst_valid", 32'(valid), 0);
        rstn = 1'b1;
        run_window("postreset", 4, 4, 4);

        // L=0 from reset: every edge strobes, dat_o is dat_i one cycle later
        rstn = 1'b0;
        log2 = 4'd0;
        cyc(0, 1'b0);
        rstn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc(i * 300 - 1500, 1'b0);
            check("l0_valid", 32'(valid), 1);
            check("l0_dat", dat_o, i * 300 - 1500);
            check("l0_settled", 32'(settled), 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/red_pitaya_decimate_block.md
RED_PITAYA_DECIMATE_BLOCK -- requirements
Module: red_pitaya_decimate_block

Interface
REQ-001 SHALL have parameter SIGNALBITS, default 14, meaning the signed sample width of dat_i and dat_o (W below).
REQ-002 SHALL have parameter MAXLOG2, default 10, meaning the largest supported log2 decimation ratio.
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 SHALL have port rstn_i, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port log2_decim, input, 4 bits: requested decimation exponent L.
REQ-006 SHALL have port clear_i, input, 1 bit: synchronous window abort.
REQ-007 SHALL have port dat_i, input, W bits signed: the filter-chain output sample, one per cycle.
REQ-008 SHALL have port dat_o, output, W bits signed: the decimated sample.
REQ-009 SHALL have port valid_o, output, 1 bit: one-cycle strobe marking a new dat_o.
REQ-010 SHALL have port settled_o, output, 1 bit: high once a full window has completed since the last restart.

Function
REQ-011 SHALL take effective L = min(log2_decim, MAXLOG2), registered once per cycle as L_r.
REQ-012 SHALL accumulate dat_i every cycle in a signed accumulator of W+MAXLOG2 bits, with no wrap possible.
REQ-013 SHALL count samples 0..2^L_r-1; the window ends on the cycle with count = 2^L_r-1.
REQ-014 SHALL, on window end, register dat_o = (acc + dat_i) >>> L_r (arithmetic shift), assert valid_o the next cycle only, and restart with acc=0, count=0.
REQ-015 SHALL, with L_r=0, assert valid_o every cycle, dat_o = dat_i delayed by one cycle.
REQ-016 SHALL hold dat_o between strobes.
REQ-017 SHALL implement FSM FILL -> RUN: reset, clear_i or L_r change enter FILL; the first window end in FILL moves to RUN; settled_o = (state==RUN).
REQ-018 SHALL, when L_r changes, discard the current window: no valid_o, acc=0, count=0, state FILL.
REQ-019 SHALL, with clear_i high, discard the current window exactly as in REQ-018; clear_i wins over a simultaneous window end (no strobe).
REQ-020 SHALL keep dat_o unchanged on clear or L_r change.

Reset
REQ-021 SHALL, with rstn_i low, asynchronously force dat_o=0, valid_o=0, settled_o=0, acc=0, count=0, L_r=0, state FILL.
REQ-022 SHALL, on reset asserted mid-window, drop the partial window with no strobe; the first window after release starts on the first clock edge with rstn_i high.

Configuration
REQ-023 SHALL, with macro PYRPL_DECIM_ROUND_EN defined and L_r>0, add 2^(L_r-1) before the shift (round half up); no saturation is needed because the result stays in range.
REQ-024 SHALL, without PYRPL_DECIM_ROUND_EN, truncate toward minus infinity (plain arithmetic shift).

Structure
REQ-025 SHALL place the FSM state encoding (FILL, RUN) and the MAXLOG2 default in the shared pyrpl package.
REQ-026 SHALL isolate the counter and FSM in one sub-module, red_pitaya_decim_ctrl, with outputs window_end, restart and settled; accumulate and shift stay in the top.

Verification
REQ-027 SHALL check: L=2, dat_i constant 100 -> valid_o every 4th cycle, dat_o=100; settled_o rises with the first strobe.
REQ-028 SHALL check: L=2, inputs 1,2,2,2 -> dat_o=1 truncating, 2 with PYRPL_DECIM_ROUND_EN; inputs -5,-5,-5,-6 -> -6 truncating, -5 rounding.
REQ-029 SHALL check: L=10, dat_i=8191 for 1024 cycles -> dat_o=8191; dat_i=-8192 -> dat_o=-8192, no overflow; log2_decim=15 behaves as L=10.
REQ-030 SHALL check: L=0, ramp input -> dat_o equals dat_i one cycle later, valid_o constantly high after reset.
REQ-031 SHALL check: L=3, clear_i pulsed at sample 5, and separately on the window-end cycle -> no strobe, settled_o=0, the next strobe comes 8 cycles after clear with the post-clear average.
REQ-032 SHALL check: rstn_i low at sample 3 of an L=2 window -> all outputs 0 immediately (asynchronous), with no strobe for the partial window; separately, L changed 2->3 mid-window -> old window discarded, next strobe after 8 samples.
